cvxif_pau_ctrl: RTL and testbench

//  Sequencer between the CV-X-IF coprocessor port and a multi-cycle posit arithmetic unit (PAU) core.

---
 rtl/cvxif_pau_pkg.sv | 25 ++
 rtl/cvxif_pau_decode.sv | 40 ++++
 rtl/cvxif_pau_ctrl.sv | 123 ++++++++++++
 tb/tb_cvxif_pau_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_pau_pkg.sv
// Shared types and constants for the CV-X-IF posit arithmetic unit controller.
// Holds the custom-0 opcode, funct3 operation codes, the posit NaR pattern and the FSM state enum.
package cvxif_pau_pkg;

  localparam logic [6:0] PAU_OPCODE = 7'b0001011;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4
  } pau_op_e;

  // 32-bit posit Not-a-Real: sign bit set, all other bits clear.
  localparam logic [31:0] POSIT_NAR = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPER = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/cvxif_pau_decode.sv
// Combinational decoder for offered custom-0 instructions.
// Produces the accept flag, the funct3 operation and the {rs2,rs1} read mask.
module cvxif_pau_decode
  import cvxif_pau_pkg::*;
#(
  parameter logic [6:0] OPCODE = PAU_OPCODE
) (
  input  logic [31:0] instr,
  output logic        accept,
  output logic [2:0]  op,
  output logic [1:0]  register_read
);

  // Register and rd fields are routed by the CPU, not by this unit.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    op            = instr[14:12];
    accept        = 1'b0;
    register_read = 2'b00;
    if (instr[6:0] == OPCODE && instr[31:25] == 7'd0) begin
      case (instr[14:12])
        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
          accept        = 1'b1;
          register_read = 2'b11;
        end
        OP_SQRT: begin
          accept        = 1'b1;
          register_read = 2'b01;
        end
        default: begin
          accept        = 1'b0;
          register_read = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/cvxif_pau_ctrl.sv
// Sequencer between the CV-X-IF coprocessor port and a multi-cycle posit arithmetic core.
// One instruction in flight: issue -> operand capture -> execute (with timeout) -> result hold.
module cvxif_pau_ctrl
  import cvxif_pau_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter int         TIMEOUT = 64,
  parameter logic [6:0] OPCODE  = PAU_OPCODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_req_instr,
  output logic            issue_resp_accept,
  output logic            issue_resp_writeback,
  output logic [1:0]      issue_resp_register_read,
  input  logic            register_valid,
  output logic            register_ready,
  input  logic [XLEN-1:0] register_rs0,
  input  logic [XLEN-1:0] register_rs1,
  input  logic [1:0]      register_rs_valid,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result_data,
  output logic            pau_start,
  output logic [2:0]      pau_op,
  output logic [XLEN-1:0] pau_a,
  output logic [XLEN-1:0] pau_b,
  input  logic            pau_done,
  input  logic [XLEN-1:0] pau_result,
  output state_e          state_dbg
);

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT);
  localparam logic [XLEN-1:0] NAR     = {1'b1, {(XLEN-1){1'b0}}};

  state_e        state;
  logic [1:0]    mask_q;
  logic [CW-1:0] cnt;
  logic          dec_accept;
  logic [2:0]    dec_op;
  logic [1:0]    dec_mask;
  logic          issue_hs;
  logic          operands_ok;

  cvxif_pau_decode #(.OPCODE(OPCODE)) u_decode (
    .instr         (issue_req_instr),
    .accept        (dec_accept),
    .op            (dec_op),
    .register_read (dec_mask)
  );

  // All three channels transfer on the cycle where valid && ready are both high;
  // issue response fields are only meaningful in that same cycle and read 0 otherwise.
  assign issue_ready              = (state == S_IDLE) && !rst;
  assign issue_hs                 = issue_valid && issue_ready;
  assign issue_resp_accept        = issue_hs && dec_accept;
  assign issue_resp_writeback     = issue_hs && dec_accept;
  assign issue_resp_register_read = issue_hs ? dec_mask : 2'b00;
  assign operands_ok              = register_valid && ((register_rs_valid & mask_q) == mask_q);
  assign state_dbg                = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      mask_q         <= 2'b00;
      cnt            <= '0;
      register_ready <= 1'b0;
      result_valid   <= 1'b0;
      result_data    <= '0;
      pau_start      <= 1'b0;
      pau_op         <= 3'd0;
      pau_a          <= '0;
      pau_b          <= '0;
    end else begin
      pau_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_hs && dec_accept) begin
            pau_op         <= dec_op;
            mask_q         <= dec_mask;
            register_ready <= 1'b1;
            state          <= S_OPER;
          end
        end
        S_OPER: begin
          if (operands_ok) begin
            pau_a          <= register_rs0;
            pau_b          <= mask_q[1] ? register_rs1 : '0;
            register_ready <= 1'b0;
            pau_start      <= 1'b1;
            cnt            <= '0;
            state          <= S_EXEC;
          end
        end
        S_EXEC: begin
          // pau_start is still high in the launch cycle, so a done seen there is ignored.
          if (pau_done && !pau_start) begin
            result_data  <= pau_result;
            result_valid <= 1'b1;
            state        <= S_RESP;
          end else if (cnt == CNT_MAX) begin
            result_data  <= NAR;
            result_valid <= 1'b1;
            state        <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvxif_pau_ctrl.sv
// Self-checking bench for cvxif_pau_ctrl: directed cases plus randomized instructions,
// operand timing, core latency and result back-pressure against a transaction-level model.
module tb_cvxif_pau_ctrl;

  localparam int          XLEN    = 32;
  localparam int          TIMEOUT = 64;
  localparam logic [31:0] NAR     = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_req_instr;
  logic        issue_resp_accept;
  logic        issue_resp_writeback;
  logic [1:0]  issue_resp_register_read;
  logic        register_valid;
  logic        register_ready;
  logic [31:0] register_rs0;
  logic [31:0] register_rs1;
  logic [1:0]  register_rs_valid;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic        pau_start;
  logic [2:0]  pau_op;
  logic [31:0] pau_a;
  logic [31:0] pau_b;
  logic        pau_done;
  logic [31:0] pau_result;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (pau_start) start_cnt <= start_cnt + 1;

  cvxif_pau_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .issue_valid              (issue_valid),
    .issue_ready              (issue_ready),
    .issue_req_instr          (issue_req_instr),
    .issue_resp_accept        (issue_resp_accept),
    .issue_resp_writeback     (issue_resp_writeback),
    .issue_resp_register_read (issue_resp_register_read),
    .register_valid           (register_valid),
    .register_ready           (register_ready),
    .register_rs0             (register_rs0),
    .register_rs1             (register_rs1),
    .register_rs_valid        (register_rs_valid),
    .result_valid             (result_valid),
    .result_ready             (result_ready),
    .result_data              (result_data),
    .pau_start                (pau_start),
    .pau_op                   (pau_op),
    .pau_a                    (pau_a),
    .pau_b                    (pau_b),
    .pau_done                 (pau_done),
    .pau_result               (pau_result),
    .state_dbg                (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_accept(input logic [31:0] i);
    return (i[6:0] == 7'h0B) && (i[31:25] == 7'd0) && (i[14:12] <= 3'd4);
  endfunction

  function automatic logic [1:0] m_mask(input logic [31:0] i);
    if (!m_accept(i)) return 2'b00;
    return (i[14:12] == 3'd4) ? 2'b01 : 2'b11;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1; issue_valid = 1'b1; issue_req_instr = 32'h0000_000B;
    register_valid = 1'b0; register_rs_valid = 2'b00;
    result_ready = 1'b0; pau_done = 1'b0;
    @(negedge clk);
    check("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
    check("rst_accept",      {31'b0, issue_resp_accept}, 32'd0);
    check("rst_writeback",   {31'b0, issue_resp_writeback}, 32'd0);
    check("rst_mask",        {30'b0, issue_resp_register_read}, 32'd0);
    check("rst_reg_ready",   {31'b0, register_ready}, 32'd0);
    check("rst_result_valid",{31'b0, result_valid}, 32'd0);
    check("rst_result_data", result_data, 32'd0);
    check("rst_pau_start",   {31'b0, pau_start}, 32'd0);
    check("rst_pau_op",      {29'b0, pau_op}, 32'd0);
    check("rst_pau_a",       pau_a, 32'd0);
    check("rst_pau_b",       pau_b, 32'd0);
    issue_valid = 1'b0; rst = 1'b0;
    #1;
    check("post_rst_issue_ready", {31'b0, issue_ready}, 32'd1);
  endtask

  // d: cycle after pau_start at which the core pulses done (0 = launch cycle, <0 = never).
  // abort: 0 none, 1 reset while executing, 2 reset while holding the result.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rsv0, input int rsv_dly, input int d,
                        input logic [31:0] core_res, input int ready_dly,
                        input bit late_done, input int abort);
    bit          acc;
    bit          seen;
    logic [1:0]  mask;
    logic [31:0] exp_b, exp_res, sb_res;
    int          exp_lat, rvk, s0;
    acc  = m_accept(instr);
    mask = m_mask(instr);
    @(negedge clk);
    issue_valid = 1'b1; issue_req_instr = instr;
    #1;
    check("issue_ready", {31'b0, issue_ready}, 32'd1);
    check("accept",      {31'b0, issue_resp_accept}, {31'b0, acc});
    check("writeback",   {31'b0, issue_resp_writeback}, {31'b0, acc});
    check("rd_mask",     {30'b0, issue_resp_register_read}, {30'b0, mask});
    s0 = start_cnt;
    @(negedge clk);
    issue_valid = 1'b0; issue_req_instr = $urandom;
    if (!acc) begin
      repeat (3) @(negedge clk);
      check("rej_issue_ready", {31'b0, issue_ready}, 32'd1);
      check("rej_no_start", 32'(start_cnt), 32'(s0));
      return;
    end
    exp_b = (instr[14:12] == 3'd4) ? 32'd0 : b;
    if (d >= 1 && d <= TIMEOUT) begin exp_res = core_res; exp_lat = d + 1; end
    else begin exp_res = NAR; exp_lat = TIMEOUT + 1; end
    exp_q.push_back(exp_res);
    check("busy_issue_ready", {31'b0, issue_ready}, 32'd0);
    check("reg_ready", {31'b0, register_ready}, 32'd1);
    register_valid = 1'b1; register_rs0 = a; register_rs1 = b; register_rs_valid = rsv0;
    if ((rsv0 & mask) != mask) begin
      for (int w = 0; w < rsv_dly; w++) begin
        @(negedge clk);
        check("oper_wait_ready", {31'b0, register_ready}, 32'd1);
        check("oper_no_start", {31'b0, pau_start}, 32'd0);
      end
      register_rs_valid = 2'b11;
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (pau_start) seen = 1'b1;
    end
    check("start_seen", {31'b0, seen}, 32'd1);
    if (!seen) begin void'(exp_q.pop_back()); register_valid = 1'b0; return; end
    register_valid = 1'b0; register_rs_valid = 2'b00;
    check("pau_a", pau_a, a);
    check("pau_b", pau_b, exp_b);
    check("pau_op", {29'b0, pau_op}, {29'b0, instr[14:12]});
    check("reg_ready_drop", {31'b0, register_ready}, 32'd0);
    pau_done = (d == 0); pau_result = $urandom;
    rvk = -1;
    for (int kk = 1; kk <= TIMEOUT + 8 && rvk < 0; kk++) begin
      @(negedge clk);
      pau_done   = (kk == d);
      pau_result = (kk == d) ? core_res : $urandom;
      if (kk == 1) begin
        check("start_once", {31'b0, pau_start}, 32'd0);
        check("b_stable", pau_b, exp_b);
      end
      if (abort == 1 && kk == 3) begin
        void'(exp_q.pop_back());
        apply_reset();
        return;
      end
      if (result_valid) rvk = kk;
    end
    pau_done = 1'b0;
    check("latency", 32'(rvk), 32'(exp_lat));
    if (rvk < 0) begin void'(exp_q.pop_back()); return; end
    sb_res = exp_q.pop_front();
    check("result", result_data, sb_res);
    if (abort == 2) begin apply_reset(); return; end
    for (int r = 0; r < ready_dly; r++) begin
      if (late_done && r == 0) begin pau_done = 1'b1; pau_result = ~sb_res; end
      @(negedge clk);
      pau_done = 1'b0;
      check("hold_valid", {31'b0, result_valid}, 32'd1);
      check("hold_data", result_data, sb_res);
      check("hold_issue_ready", {31'b0, issue_ready}, 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("rv_drop", {31'b0, result_valid}, 32'd0);
    check("idle_ready", {31'b0, issue_ready}, 32'd1);
    check("single_start", 32'(start_cnt - s0), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int          sel;
    i = $urandom;
    i[6:0]   = 7'h0B;
    i[31:25] = 7'd0;
    i[14:12] = 3'($urandom_range(0, 4));
    sel = $urandom_range(0, 9);
    if (sel == 7)      i[6:0]   = 7'h33;
    else if (sel == 8) i[31:25] = 7'($urandom_range(1, 127));
    else if (sel == 9) i[14:12] = 3'($urandom_range(5, 7));
    return i;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_req_instr = 32'd0;
    register_valid = 1'b0; register_rs0 = 32'd0; register_rs1 = 32'd0;
    register_rs_valid = 2'b00; result_ready = 1'b0; pau_done = 1'b0; pau_result = 32'd0;
    @(negedge clk);
    apply_reset();

    run_op(32'h0000_000B, 32'h4000_0000, 32'h4000_0000, 2'b11, 0, 5, 32'h4800_0000, 0, 1'b0, 0);
    run_op(32'h0000_0033, 32'h1, 32'h2, 2'b11, 0, 5, 32'h3, 0, 1'b0, 0);
    run_op(32'h0200_000B, 32'h1, 32'h2, 2'b11, 0, 5, 32'h3, 0, 1'b0, 0);
    run_op(32'h0000_400B, 32'h3C00_0000, 32'hDEAD_BEEF, 2'b01, 0, 3, 32'h3A00_0000, 1, 1'b0, 0);
    run_op(32'h0000_000B, 32'h1234_5678, 32'h9ABC_DEF0, 2'b10, 3, 2, 32'h5555_AAAA, 0, 1'b0, 0);
    run_op(32'h0000_100B, 32'h4000_0000, 32'h3000_0000, 2'b11, 0, -1, 32'h0, 10, 1'b1, 0);
    run_op(32'h0000_200B, 32'h4000_0000, 32'h4000_0000, 2'b11, 0, 0, 32'h1111_1111, 0, 1'b0, 0);
    run_op(32'h0000_000B, 32'h4000_0000, 32'h4000_0000, 2'b11, 0, 20, 32'h4800_0000, 0, 1'b0, 1);
    run_op(32'h0000_300B, 32'h4000_0000, 32'h4000_0000, 2'b11, 0, 4, 32'h7777_0000, 3, 1'b0, 2);
    run_op(32'h0000_000B, 32'h4000_0000, 32'h4000_0000, 2'b11, 0, 5, 32'h4800_0000, 0, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] ins;
      int          d, rd;
      bit          late;
      ins = rand_instr();
      case ($urandom_range(0, 19))
        0:       d = -1;
        1:       d = 0;
        default: d = $urandom_range(1, 12);
      endcase
      late = (d < 0) && ($urandom_range(0, 1) == 1);
      rd   = late ? $urandom_range(1, 3) : $urandom_range(0, 3);
      run_op(ins, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 3),
             d, $urandom, rd, late, 0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
